// File: rtl/contador_direccional_if.sv
// Sensor inputs, clear and occupancy outputs of the bidirectional people counter.
// The master drives the beams and clear; the slave (the counter) drives occupancy and event pulses.
interface contador_direccional_if #(
    parameter int WIDTH = 8
);
    logic             sensor_a;
    logic             sensor_b;
    logic             clr;
    logic [WIDTH-1:0] count;
    logic             full;
    logic             empty;
    logic             evt_in;
    logic             evt_out;
    logic             err;

    modport master (
        output sensor_a, sensor_b, clr,
        input  count, full, empty, evt_in, evt_out, err
    );

    modport slave (
        input  sensor_a, sensor_b, clr,
        output count, full, empty, evt_in, evt_out, err
    );
endinterface

// File: rtl/contador_direccional.sv
// Bidirectional occupancy counter driven by two IR beams (a = outer, b = inner).
// Latency: pin change to debounced level 2+DEB_CYCLES cycles, plus one cycle to the count/event update.
// Backpressure: none; the counter is free-running and the event pulses are single-cycle and unacknowledged.
module contador_direccional #(
    parameter int WIDTH      = 8,
    parameter int CAPACITY   = 100,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input logic                   clk,
    input logic                   rst_n,
    contador_direccional_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH-1:0] CAP_W = WIDTH'(CAPACITY);

    generate
        if (CAPACITY > (1 << WIDTH) - 1) begin : g_cap_check
            $error("CAPACITY does not fit in WIDTH bits");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A, WAIT_CLR
    } state_t;

    logic [1:0]       raw, sync1, sync2, filt;
    logic [DW-1:0]    deb_cnt [2];
    logic             fa, fb;
    state_t           state, nxt;
    logic [TW-1:0]    tcnt;
    logic             tmo_hit, done_in, done_out, bad;
    logic             inc, dec, err_nxt;
    logic [WIDTH-1:0] cnt_q;
    logic             evt_in_q, evt_out_q, err_q;

    assign raw = {bus.sensor_b, bus.sensor_a};
    assign fa  = filt[0];
    assign fb  = filt[1];

    // Two-flop synchronizer, then a level is accepted only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= '0;
            sync2      <= '0;
            filt       <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));

    // Any transition that skips a stage (both beams changing at once) is treated as invalid.
    always_comb begin
        nxt      = state;
        done_in  = 1'b0;
        done_out = 1'b0;
        bad      = 1'b0;
        unique case (state)
            IDLE: case ({fa, fb})
                2'b10:   nxt = ENT_A;
                2'b01:   nxt = EXT_B;
                2'b11:   bad = 1'b1;
                default: nxt = IDLE;
            endcase
            ENT_A: case ({fa, fb})
                2'b11:   nxt = ENT_AB;
                2'b00:   nxt = IDLE;
                2'b01:   bad = 1'b1;
                default: nxt = ENT_A;
            endcase
            ENT_AB: case ({fa, fb})
                2'b01:   nxt = ENT_B;
                2'b10:   nxt = ENT_A;
                2'b00:   bad = 1'b1;
                default: nxt = ENT_AB;
            endcase
            ENT_B: case ({fa, fb})
                2'b11:   nxt = ENT_AB;
                2'b00:   begin nxt = IDLE; done_in = 1'b1; end
                2'b10:   bad = 1'b1;
                default: nxt = ENT_B;
            endcase
            EXT_B: case ({fa, fb})
                2'b11:   nxt = EXT_AB;
                2'b00:   nxt = IDLE;
                2'b10:   bad = 1'b1;
                default: nxt = EXT_B;
            endcase
            EXT_AB: case ({fa, fb})
                2'b10:   nxt = EXT_A;
                2'b01:   nxt = EXT_B;
                2'b00:   bad = 1'b1;
                default: nxt = EXT_AB;
            endcase
            EXT_A: case ({fa, fb})
                2'b11:   nxt = EXT_AB;
                2'b00:   begin nxt = IDLE; done_out = 1'b1; end
                2'b01:   bad = 1'b1;
                default: nxt = EXT_A;
            endcase
            default: if (!fa && !fb) nxt = IDLE;
        endcase
        if (nxt == state && state != IDLE && state != WAIT_CLR && tmo_hit) bad = 1'b1;
        if (bad) nxt = WAIT_CLR;
        if (bus.clr) begin
            nxt      = WAIT_CLR;
            done_in  = 1'b0;
            done_out = 1'b0;
            bad      = 1'b0;
        end
    end

    always_comb begin
        inc     = done_in  && (cnt_q != CAP_W);
        dec     = done_out && (cnt_q != '0);
        err_nxt = bad || (done_in && cnt_q == CAP_W) || (done_out && cnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= '0;
            cnt_q     <= '0;
            evt_in_q  <= 1'b0;
            evt_out_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (bus.clr || nxt != state || state == IDLE || state == WAIT_CLR) tcnt <= '0;
            else                                                              tcnt <= tcnt + 1'b1;
            if (bus.clr)  cnt_q <= '0;
            else if (inc) cnt_q <= cnt_q + 1'b1;
            else if (dec) cnt_q <= cnt_q - 1'b1;
            evt_in_q  <= inc;
            evt_out_q <= dec;
            err_q     <= err_nxt;
        end
    end

    assign bus.count   = cnt_q;
    assign bus.full    = (cnt_q == CAP_W);
    assign bus.empty   = (cnt_q == '0);
    assign bus.evt_in  = evt_in_q;
    assign bus.evt_out = evt_out_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_contador_direccional.sv
// Directed scenarios for the beam counter; expected pulses are queued by the stimulus and
// popped by a monitor whenever the counter emits evt_in, evt_out or err.
module tb_contador_direccional;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    typedef struct {
        logic [2:0] ev;     // {evt_in, evt_out, err}
        logic [7:0] cnt;
        logic       full;
        logic       empty;
    } exp_t;
    exp_t q[$];

    contador_direccional_if #(.WIDTH(8)) bus ();

    contador_direccional #(
        .WIDTH(8), .CAPACITY(3), .DEB_CYCLES(4), .TIMEOUT(50)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [2:0] ev, input logic [7:0] cnt, input logic f, input logic e);
        exp_t x;
        x.ev = ev; x.cnt = cnt; x.full = f; x.empty = e;
        q.push_back(x);
    endtask

    task automatic step(input logic a, input logic b, input int n);
        bus.sensor_a = a;
        bus.sensor_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic entry();
        step(1, 0, 20); step(1, 1, 20); step(0, 1, 20); step(0, 0, 20);
    endtask

    task automatic exit_seq();
        step(0, 1, 20); step(1, 1, 20); step(1, 0, 20); step(0, 0, 20);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        check({name, "_pending"}, q.size(), 0);
        q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_count"}, bus.count, 0);
        check({name, "_empty"}, bus.empty, 1);
        check({name, "_full"},  bus.full,  0);
        check({name, "_evts"},  {bus.evt_in, bus.evt_out, bus.err}, 3'b000);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.evt_in || bus.evt_out || bus.err)) begin
            if (q.size() == 0) begin
                check("unexpected_evt", {bus.evt_in, bus.evt_out, bus.err}, 3'b000);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("evt",   {bus.evt_in, bus.evt_out, bus.err}, e.ev);
                check("count", bus.count, e.cnt);
                check("full",  bus.full,  e.full);
                check("empty", bus.empty, e.empty);
            end
        end
    end

    initial begin
        bus.sensor_a = 1'b0;
        bus.sensor_b = 1'b0;
        bus.clr      = 1'b0;
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 5);

        // Entry from empty.
        push(3'b100, 8'd1, 1'b0, 1'b0);
        entry();
        drain("entry");
        check("entry_count", bus.count, 1);
        check("entry_empty", bus.empty, 0);

        // Short glitch is filtered, then an exit.
        step(1, 0, 2); step(0, 0, 20);
        check("glitch_count", bus.count, 1);
        push(3'b010, 8'd0, 1'b0, 1'b1);
        exit_seq();
        drain("exit");
        check("exit_empty", bus.empty, 1);

        // Saturation at CAPACITY=3.
        push(3'b100, 8'd1, 1'b0, 1'b0);
        push(3'b100, 8'd2, 1'b0, 1'b0);
        push(3'b100, 8'd3, 1'b1, 1'b0);
        push(3'b001, 8'd3, 1'b1, 1'b0);
        repeat (4) entry();
        drain("saturate");
        check("sat_count", bus.count, 3);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        step(0, 0, 5);
        check("clr_count", bus.count, 0);

        // Abort without b, then a held past the timeout.
        step(1, 0, 20); step(0, 0, 20);
        check("abort_count", bus.count, 0);
        push(3'b001, 8'd0, 1'b0, 1'b1);
        step(1, 0, 60); step(0, 0, 20);
        drain("timeout");

        // Both beams at once, then clr landing on the completion edge.
        push(3'b001, 8'd0, 1'b0, 1'b1);
        step(1, 1, 20); step(0, 0, 20);
        drain("simul");
        push(3'b100, 8'd1, 1'b0, 1'b0);
        entry();
        drain("pre_clr");
        step(1, 0, 20); step(1, 1, 20); step(0, 1, 20);
        step(0, 0, 6);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        step(0, 0, 20);
        check("clr_completion_count", bus.count, 0);

        // Reset pulse during ENT_AB with count=1; beams still both high after release.
        push(3'b100, 8'd1, 1'b0, 1'b0);
        entry();
        drain("pre_reset");
        step(1, 0, 20); step(1, 1, 10);
        rst_n = 1'b0;
        #10;
        check_reset_outputs("mid_reset");
        #10;
        rst_n = 1'b1;
        push(3'b001, 8'd0, 1'b0, 1'b1);
        step(1, 1, 20); step(0, 0, 20);
        drain("post_reset_err");
        push(3'b100, 8'd1, 1'b0, 1'b0);
        entry();
        drain("post_reset_entry");
        check("final_count", bus.count, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/contador_direccional.md
CONTADOR_DIRECCIONAL -- requirements
Module: contador_direccional

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which is the occupancy counter width in bits.
REQ-002 The module SHALL have parameter CAPACITY, default 100, which is the maximum occupancy; it SHALL be checked to be at most 2^WIDTH-1.
REQ-003 The module SHALL have parameter DEB_CYCLES, default 4, which is the number of consecutive stable cycles needed to accept a sensor level.
REQ-004 The module SHALL have parameter TIMEOUT, default 1000, which is the maximum number of cycles a crossing sequence may stay incomplete.
REQ-005 clk  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 sensor_a  input  1  outer infrared beam, asynchronous, 1 = beam interrupted.
REQ-008 sensor_b  input  1  inner infrared beam, asynchronous, 1 = beam interrupted.
REQ-009 clr  input  1  synchronous clear of the count and the sequence FSM.
REQ-010 count  output  WIDTH  current occupancy.
REQ-011 full  output  1  high when count == CAPACITY.
REQ-012 empty  output  1  high when count == 0.
REQ-013 evt_in  output  1  one-cycle pulse on each accepted entry.
REQ-014 evt_out  output  1  one-cycle pulse on each accepted exit.
REQ-015 err  output  1  one-cycle pulse on a rejected or invalid event.

Function
REQ-016 Input conditioning SHALL be identical for each sensor: a 2-flop synchronizer, then a debounce filter.
REQ-017 The debounced level fa/fb SHALL change only after the synchronized value has differed from it for DEB_CYCLES consecutive cycles.
REQ-018 Latency from a pin change to a debounced change SHALL be 2+DEB_CYCLES cycles.
REQ-019 Any glitch shorter than DEB_CYCLES cycles SHALL be ignored.
REQ-020 The FSM SHALL have the states IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A and WAIT_CLR, and SHALL be evaluated on the debounced levels (fa, fb).
REQ-021 In IDLE: (1,0) SHALL go to ENT_A; (0,1) SHALL go to EXT_B; (1,1) SHALL go to WAIT_CLR with an err pulse; (0,0) SHALL stay in IDLE.
REQ-022 In ENT_A: (1,1) SHALL go to ENT_AB; (0,0) SHALL go to IDLE with no count change and no err.
REQ-023 In ENT_AB: (0,1) SHALL go to ENT_B; (1,0) SHALL go back to ENT_A.
REQ-024 In ENT_B: (1,1) SHALL go back to ENT_AB; (0,0) SHALL complete an entry and go to IDLE.
REQ-025 The exit path SHALL mirror the entry path with a and b swapped: EXT_B, then EXT_AB, then EXT_A; (0,0) in EXT_A SHALL complete an exit.
REQ-026 Any state other than IDLE and WAIT_CLR held for TIMEOUT consecutive cycles SHALL pulse err and go to WAIT_CLR.
REQ-027 The TIMEOUT cycle counter SHALL restart on every state change.
REQ-028 WAIT_CLR SHALL go to IDLE only when (0,0); no count change SHALL occur while in it.
REQ-029 On entry completion with count < CAPACITY: count+1 and evt_in SHALL be applied on the same edge the FSM returns to IDLE.
REQ-030 On entry completion with count == CAPACITY: count SHALL hold, err SHALL pulse, and evt_in SHALL stay low.
REQ-031 On exit completion with count > 0: count-1 and evt_out SHALL be applied on the same edge.
REQ-032 On exit completion with count == 0: count SHALL hold, err SHALL pulse, and evt_out SHALL stay low.
REQ-033 count arithmetic SHALL never wrap.
REQ-034 full and empty SHALL be combinational decodes of the registered count.
REQ-035 When clr is high: count SHALL become 0, the FSM SHALL go to WAIT_CLR, the timeout counter SHALL become 0, and evt_in, evt_out and err SHALL be suppressed that cycle.
REQ-036 clr SHALL override a completion occurring in the same cycle.
REQ-037 At most one of evt_in, evt_out and err SHALL be high in any cycle.

Reset
REQ-038 While rst_n is low: synchronizers, filters and fa/fb SHALL be 0; the FSM SHALL be IDLE; the timeout counter SHALL be 0.
REQ-039 While rst_n is low: count = 0, empty = 1, full = 0, and evt_in = evt_out = err = 0.
REQ-040 Reset asserted mid-sequence SHALL discard the sequence; after release, a sensor already high SHALL be seen as a fresh IDLE transition.

Verification (DEB_CYCLES=4, CAPACITY=3, TIMEOUT=50)
REQ-041 Scenario, entry: a high 20 cycles, then a+b high 20 cycles, then b only 20 cycles, then both low -> evt_in pulses once, count 0->1, empty 1->0.
REQ-042 Scenario, exit plus glitch: a 2-cycle a-glitch while idle -> no change; then a full exit sequence from count=1 -> evt_out pulses once, count=0, empty=1.
REQ-043 Scenario, saturation: 4 entries from count=0 -> count 1,2,3,3; full=1 after the 3rd entry; err pulses on the 4th entry with no evt_in.
REQ-044 Scenario, abort and timeout: a rises and falls without b -> no event; a held 60 cycles -> err once at the timeout, then no event until both are low.
REQ-045 Scenario, simultaneous and clr: a and b rise in the same cycle -> err, no count change; clr asserted in the completion cycle -> count=0 and no evt_in.
REQ-046 Scenario, reset mid-sequence: rst_n pulsed low for 20 ns during ENT_AB -> all outputs at reset values; a later complete entry counts normally to 1.
